// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop bank: resolution policy codes for
// the S=R=1 input and the single-bit next-state rule.
package sr_ff_pkg;

    // Action taken when both set and reset are requested on the same edge
    localparam int unsigned POL_HOLD    = 0;
    localparam int unsigned POL_FORCE_0 = 1;
    localparam int unsigned POL_FORCE_1 = 2;
    localparam int unsigned POL_TOGGLE  = 3;

    // Next stored value of one SR bit (reset handled by the caller).
    // Unknown policy codes fall back to HOLD so a bad parameter never
    // produces surprising state changes.
    function automatic logic next_q(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned policy
    );
        logic nq;
        nq = q;
        case ({s, r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                case (policy)
                    POL_FORCE_0: nq = 1'b0;
                    POL_FORCE_1: nq = 1'b1;
                    POL_TOGGLE:  nq = ~q;
                    default:     nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// Single SR storage bit with synchronous active-high reset.
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter int unsigned INVALID_POLICY = POL_HOLD,
    parameter logic        RESET_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_q;
    logic q_d;

    // Resolve the set/reset request into the next stored value
    always_comb begin
        q_d = next_q(q_q, s, r, INVALID_POLICY);
    end

    // Storage register; reset wins over any set/reset request
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with complementary outputs.
// Optional feature macro SR_FF_INVALID_DETECT_EN adds per-bit S=R=1 flags
// (invalid) and a sticky summary flag (invalid_sticky) cleared only by rst.
module sr_flip_flop
    import sr_ff_pkg::*;
#(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned INVALID_POLICY = POL_HOLD,
    parameter logic [31:0] RESET_VAL      = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef SR_FF_INVALID_DETECT_EN
    ,
    output logic [WIDTH-1:0] invalid,
    output logic             invalid_sticky
`endif
);

    // Only bit 0 of RESET_VAL is meaningful; it is replicated to every bit
    localparam logic RESET_BIT = RESET_VAL[0];

    // One independent storage cell per bit
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            sr_ff_cell #(
                .INVALID_POLICY (INVALID_POLICY),
                .RESET_VAL      (RESET_BIT)
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .s   (s[gi]),
                .r   (r[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

    // Complement taken straight from the registers so it can never equal q
    assign qbar = ~q;

`ifdef SR_FF_INVALID_DETECT_EN
    logic [WIDTH-1:0] invalid_q;
    logic [WIDTH-1:0] invalid_d;
    logic             sticky_q;
    logic             sticky_d;

    // Flag bits seeing S=R=1 this edge and accumulate into the sticky flag
    always_comb begin
        invalid_d = s & r;
        sticky_d  = sticky_q | (|invalid_d);
    end

    // Detect registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
            sticky_q  <= sticky_d;
        end
    end

    assign invalid        = invalid_q;
    assign invalid_sticky = sticky_q;
`else
    // Detect logic absent: the bank is purely q/qbar storage
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Randomised and directed bench for sr_flip_flop, checked every cycle against
// a per-bit truth-table model across several policy/reset configurations.
module tb_sr_flip_flop;

    localparam int NCFG = 5;
    localparam int unsigned POLS [NCFG] = '{0, 1, 2, 3, 7};

    logic       clk;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;

    logic       qa, qba, qt, qbt;
    logic [3:0] q4  [NCFG];
    logic [3:0] qb4 [NCFG];

    int vectors;
    int miscompares;
    bit chk_en;

    // expected state
    logic       exp_a, exp_t;
    logic [3:0] exp4 [NCFG];

`ifdef SR_FF_INVALID_DETECT_EN
    logic [3:0] inv4 [NCFG];
    logic       stk4 [NCFG];
    logic       inva, stka, invt, stkt;
    logic [3:0] exp_inv;
    logic       exp_stk;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Width-1 default instance and width-1 toggle instance
    sr_flip_flop #(.WIDTH(1), .INVALID_POLICY(0), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .q(qa), .qbar(qba)
`ifdef SR_FF_INVALID_DETECT_EN
        , .invalid(inva), .invalid_sticky(stka)
`endif
    );

    sr_flip_flop #(.WIDTH(1), .INVALID_POLICY(3), .RESET_VAL(0)) dut_t (
        .clk(clk), .rst(rst), .s(s[0]), .r(r[0]), .q(qt), .qbar(qbt)
`ifdef SR_FF_INVALID_DETECT_EN
        , .invalid(invt), .invalid_sticky(stkt)
`endif
    );

    // Width-4 instances: every policy plus an illegal code, alternating reset value
    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
            sr_flip_flop #(.WIDTH(4), .INVALID_POLICY(POLS[gi]), .RESET_VAL(gi % 2)) u_dut (
                .clk(clk), .rst(rst), .s(s), .r(r), .q(q4[gi]), .qbar(qb4[gi])
`ifdef SR_FF_INVALID_DETECT_EN
                , .invalid(inv4[gi]), .invalid_sticky(stk4[gi])
`endif
            );
        end
    endgenerate

    // Truth-table reference: differing s/r copies s, both low holds, both high per policy
    function automatic logic [3:0] ref_next(logic [3:0] cur, logic [3:0] sv, logic [3:0] rv,
                                            int unsigned pol, logic rs, logic rval);
        logic [3:0] n;
        if (rs) return {4{rval}};
        for (int b = 0; b < 4; b++) begin
            if (sv[b] != rv[b])      n[b] = sv[b];
            else if (!sv[b])         n[b] = cur[b];
            else if (pol == 1)       n[b] = 1'b0;
            else if (pol == 2)       n[b] = 1'b1;
            else if (pol == 3)       n[b] = !cur[b];
            else                     n[b] = cur[b];
        end
        return n;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Model update on every rising edge
    always @(posedge clk) begin
        logic [3:0] t;
        t     = ref_next({3'b0, exp_a}, s, r, 0, rst, 1'b0);
        exp_a = t[0];
        t     = ref_next({3'b0, exp_t}, s, r, 3, rst, 1'b0);
        exp_t = t[0];
        for (int i = 0; i < NCFG; i++)
            exp4[i] = ref_next(exp4[i], s, r, POLS[i], rst, 1'(i % 2));
`ifdef SR_FF_INVALID_DETECT_EN
        exp_inv = rst ? 4'b0 : (s & r);
        exp_stk = rst ? 1'b0 : (exp_stk | (|(s & r)));
`endif
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_q",    {3'b0, qa},  {3'b0, exp_a});
            chk("a_qbar", {3'b0, qba}, {3'b0, !exp_a});
            chk("t_q",    {3'b0, qt},  {3'b0, exp_t});
            chk("t_qbar", {3'b0, qbt}, {3'b0, !exp_t});
            for (int i = 0; i < NCFG; i++) begin
                chk($sformatf("w4_%0d_q", i),    q4[i],  exp4[i]);
                chk($sformatf("w4_%0d_qbar", i), qb4[i], ~exp4[i]);
`ifdef SR_FF_INVALID_DETECT_EN
                chk($sformatf("w4_%0d_inv", i), inv4[i], exp_inv);
                chk($sformatf("w4_%0d_stk", i), {3'b0, stk4[i]}, {3'b0, exp_stk});
`endif
            end
`ifdef SR_FF_INVALID_DETECT_EN
            chk("a_inv", {3'b0, inva}, {3'b0, exp_inv[0]});
`endif
        end
    end

    // Drive at a falling edge, let one rising edge sample, return at next falling edge
    task automatic cyc(logic rs, logic [3:0] sv, logic [3:0] rv);
        rst = rs;
        s   = sv;
        r   = rv;
        @(posedge clk);
        @(negedge clk);
        $display("vec rst=%b s=%b r=%b -> a=%b t=%b w4p0=%b", rs, sv, rv, qa, qt, q4[0]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst = 1'b1; s = 4'b0; r = 4'b0;
        @(negedge clk);

        // 1. reset for two edges
        cyc(1'b1, 4'b0000, 4'b0000);
        chk_en = 1'b1;
        cyc(1'b1, 4'b0000, 4'b0000);
        chk("lit_rst_q",    {3'b0, qa},  4'b0000);
        chk("lit_rst_qbar", {3'b0, qba}, 4'b0001);
        chk("lit_rst_w4_rv0", q4[0], 4'b0000);
        chk("lit_rst_w4_rv1", q4[1], 4'b1111);

        // 2. set, then hold for two edges
        cyc(1'b0, 4'b0001, 4'b0000);
        chk("lit_set_q",    {3'b0, qa},  4'b0001);
        chk("lit_set_qbar", {3'b0, qba}, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        chk("lit_hold_q", {3'b0, qa}, 4'b0001);

        // 3. reset request
        cyc(1'b0, 4'b0000, 4'b0001);
        chk("lit_clr_q",    {3'b0, qa},  4'b0000);
        chk("lit_clr_qbar", {3'b0, qba}, 4'b0001);

        // 4. S=R=1 with HOLD from q=0; toggle instance goes 0->1
        cyc(1'b0, 4'b0001, 4'b0001);
        chk("lit_inv_hold_q",    {3'b0, qa},  4'b0000);
        chk("lit_inv_hold_qbar", {3'b0, qba}, 4'b0001);
`ifdef SR_FF_INVALID_DETECT_EN
        chk("lit_inv_flag",   {3'b0, inva}, 4'b0001);
        chk("lit_inv_sticky", {3'b0, stka}, 4'b0001);
`endif
        chk("lit_tog_start", {3'b0, qt}, 4'b0001);

        // 5. toggle policy: 1 -> 0 -> 1
        cyc(1'b0, 4'b0001, 4'b0001);
        chk("lit_tog_0",    {3'b0, qt},  4'b0000);
        chk("lit_tog_0bar", {3'b0, qbt}, 4'b0001);
        cyc(1'b0, 4'b0001, 4'b0001);
        chk("lit_tog_1",    {3'b0, qt},  4'b0001);
        chk("lit_tog_1bar", {3'b0, qbt}, 4'b0000);

        // 6. width-4 independence, then reset overriding set
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0101, 4'b0010);
        chk("lit_w4_mix", q4[0], 4'b0101);
        cyc(1'b1, 4'b1111, 4'b0000);
        chk("lit_w4_rst_over_set", q4[0], 4'b0000);
`ifdef SR_FF_INVALID_DETECT_EN
        chk("lit_sticky_cleared", {3'b0, stka}, 4'b0000);
`endif
        // release with s=1 held: first edge sets
        cyc(1'b0, 4'b1111, 4'b0000);
        chk("lit_release_set", q4[0], 4'b1111);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
